// File: rtl/interface_sequencer.sv
// interface_sequencer: owns the interface_state_t FSM that gates the byte
// reader and closes the 4-phase pin handshake around exactly one datapath
// operation (byte op or hash reset) per request.
// Optional feature macro: HANDSHAKE_TIMEOUT_EN enables a BUSY watchdog that
// forces completion after TIMEOUT_CYCLES and flags it on op_error.
//
// Handshake: input_request rises -> BUSY; the operation completes -> ACK with
// input_ack high; the chip drops input_request -> IDLE, ack drops and the
// transaction is counted. input_ack is only ever high while in ACK, and a new
// request is only accepted from IDLE, so req/ack never overlap across two
// transactions.
module interface_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             input_request,
  input  logic             input_byte_pulse,
  input  logic             reset_hash_pulse,
  input  logic             router_done,
  input  logic             hash_done,
  output logic [1:0]       fsm_state,
  output logic             input_ack,
  output logic             op_error,
  output logic [CNT_W-1:0] tx_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } interface_state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_BYTE = 2'd1,
    OP_HASH = 2'd2
  } op_t;

  interface_state_t state_q;
  op_t              op_q;
  logic             first_q;
  logic             ack_q;
  logic [CNT_W-1:0] cnt_q;

  op_t  eff_op;
  logic done_hit;

`ifdef HANDSHAKE_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] timer_q;
  logic             err_q;
  logic             timeout_hit;

  // Watchdog fires on the TIMEOUT_CYCLES-th BUSY cycle.
  always_comb begin
    timeout_hit = (timer_q == TMR_LAST);
  end

  assign op_error = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = TIMEOUT_CYCLES[0];
  assign op_error = 1'b0;
`endif

  // Effective operation: on the first BUSY cycle it comes straight from the
  // reader pulses (hash wins), afterwards from the latch; NONE completes at once.
  always_comb begin
    eff_op = op_q;
    if (first_q) begin
      if (reset_hash_pulse)      eff_op = OP_HASH;
      else if (input_byte_pulse) eff_op = OP_BYTE;
      else                       eff_op = OP_NONE;
    end
    done_hit = (eff_op == OP_NONE) ||
               ((eff_op == OP_BYTE) && router_done) ||
               ((eff_op == OP_HASH) && hash_done);
  end

  // Handshake FSM with registered state, ack, error flag and counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      first_q <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef HANDSHAKE_TIMEOUT_EN
      timer_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (input_request) begin
            state_q <= ST_BUSY;
            first_q <= 1'b1;
            op_q    <= OP_NONE;
`ifdef HANDSHAKE_TIMEOUT_EN
            timer_q <= '0;
            err_q   <= 1'b0;
`endif
          end
        end
        ST_BUSY: begin
          first_q <= 1'b0;
          if (first_q) op_q <= eff_op;
`ifdef HANDSHAKE_TIMEOUT_EN
          timer_q <= timer_q + 1'b1;
`endif
          if (done_hit) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
          end
`ifdef HANDSHAKE_TIMEOUT_EN
          else if (timeout_hit) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            err_q   <= 1'b1;
          end
`endif
        end
        ST_ACK: begin
          if (!input_request) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            op_q    <= OP_NONE;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          first_q <= 1'b0;
        end
      endcase
    end
  end

  assign fsm_state = state_q;
  assign input_ack = ack_q;
  assign tx_count  = cnt_q;

endmodule

// File: tb/tb_interface_sequencer.sv
// Testbench for interface_sequencer: transaction-level reference model that
// predicts, for each cycle, the state/ack/error/count the DUT must show.
module tb_interface_sequencer;

  localparam int CNT_W = 2;
  localparam int TMO   = 8;
  localparam int W     = 4 + CNT_W;
`ifdef HANDSHAKE_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic nrst;
  logic req, bp, hp, rd, hd;
  logic [1:0]       fsm_state;
  logic             input_ack;
  logic             op_error;
  logic [CNT_W-1:0] tx_count;

  always #5 clk = ~clk;

  interface_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (CNT_W)
  ) dut (
    .clk             (clk),
    .nrst            (nrst),
    .input_request   (req),
    .input_byte_pulse(bp),
    .reset_hash_pulse(hp),
    .router_done     (rd),
    .hash_done       (hd),
    .fsm_state       (fsm_state),
    .input_ack       (input_ack),
    .op_error        (op_error),
    .tx_count        (tx_count)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int m_cnt  = 0;
  bit m_err  = 1'b0;

  function automatic logic [W-1:0] pk(input logic [1:0] st, input logic a,
                                      input logic e, input int c);
    logic [CNT_W-1:0] cv;
    cv = c[CNT_W-1:0];
    return {st, a, e, cv};
  endfunction

  // Every cycle that has a prediction is checked on the falling edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {fsm_state, input_ack, op_error, tx_count};
      n_cmp++;
      if (act !== e)
        begin
          n_fail++;
          $display("FAIL cycle_check t=%0t got st=%0d ack=%0b err=%0b cnt=%0d expected st=%0d ack=%0b err=%0b cnt=%0d",
                   $time, act[W-1:W-2], act[W-3], act[W-4], act[CNT_W-1:0],
                   e[W-1:W-2], e[W-3], e[W-4], e[CNT_W-1:0]);
        end
    end
  end

  task automatic check_lit(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic strays();
    bp = rnd(); hp = rnd(); rd = rnd(); hd = rnd();
  endtask

  // k: 0 none, 1 byte, 2 hash, 3 both pulses. d: BUSY index of the matching
  // done. never: no matching done (only with the watchdog). r: BUSY index at
  // which req drops (-1 = hold into ACK). h: ACK cycles req stays high.
  // g: idle cycles afterwards. from_reset: req already high, skip IDLE cycle.
  task automatic run_txn(input int k, input int d, input bit never, input int r,
                         input int h, input int g, input bit from_reset);
    int  len;
    int  ack_len;
    bit  drop_busy;
    bit  is_hash;
    bit  t_err;
    logic mdone, wdone;
    if (k == 0)     len = 1;
    else if (never) len = TMO;
    else            len = d + 1;
    t_err     = never && (k != 0);
    drop_busy = (r >= 0) && (r < len);
    ack_len   = drop_busy ? 1 : h + 1;
    is_hash   = (k >= 2);

    if (!from_reset) begin
      tick();
      exp_q.push_back(pk(S_IDLE, 1'b0, m_err, m_cnt));
      req = 1'b1;
      strays();
    end
    m_err = 1'b0;

    for (int i = 0; i < len; i++) begin
      tick();
      exp_q.push_back(pk(S_BUSY, 1'b0, 1'b0, m_cnt));
      req = !(drop_busy && (i >= r));
      if (i == 0) begin
        bp = (k == 1) || (k == 3);
        hp = (k >= 2);
      end else begin
        bp = rnd();
        hp = rnd();
      end
      if (k == 0) begin
        rd = rnd();
        hd = rnd();
      end else begin
        mdone = !never && (i == d);
        wdone = (i == 0) ? 1'b1 : rnd();
        if (is_hash) begin hd = mdone; rd = wdone; end
        else         begin rd = mdone; hd = wdone; end
      end
    end

    for (int j = 0; j < ack_len; j++) begin
      tick();
      exp_q.push_back(pk(S_ACK, 1'b1, t_err, m_cnt));
      req = drop_busy ? 1'b0 : (j < h);
      strays();
    end
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
    m_err = t_err;

    for (int q = 0; q < g; q++) begin
      tick();
      exp_q.push_back(pk(S_IDLE, 1'b0, m_err, m_cnt));
      req = 1'b0;
      strays();
    end
  endtask

  // Byte op completing immediately, then async reset during ACK with req held.
  task automatic reset_in_ack();
    tick();
    exp_q.push_back(pk(S_IDLE, 1'b0, m_err, m_cnt));
    req = 1'b1; bp = 1'b0; hp = 1'b0; rd = 1'b0; hd = 1'b0;
    tick();
    exp_q.push_back(pk(S_BUSY, 1'b0, 1'b0, m_cnt));
    bp = 1'b1; rd = 1'b1;
    tick();
    bp = 1'b0; rd = 1'b0;
    #2;
    nrst  = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
    exp_q.push_back(pk(S_IDLE, 1'b0, 1'b0, 0));
    #4;
    nrst = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k, d, r, h, g;
    bit nv;
    nrst = 1'b0;
    req = 1'b0; bp = 1'b0; hp = 1'b0; rd = 1'b0; hd = 1'b0;
    tick();
    exp_q.push_back(pk(S_IDLE, 1'b0, 1'b0, 0));
    tick();
    exp_q.push_back(pk(S_IDLE, 1'b0, 1'b0, 0));
    nrst = 1'b1;
    check_lit("reset_state", int'(fsm_state), 0);
    check_lit("reset_ack", int'(input_ack), 0);
    check_lit("reset_count", int'(tx_count), 0);

    // byte op, router_done 3 cycles after the pulse, ack held 2 cycles
    run_txn(1, 3, 1'b0, -1, 1, 1, 1'b0);
    check_lit("byte_txn_count", int'(tx_count), 1);
    check_lit("byte_txn_idle", int'(fsm_state), 0);
    // hash op with hash_done in the pulse cycle
    run_txn(2, 0, 1'b0, -1, 0, 1, 1'b0);
    check_lit("hash_txn_count", int'(tx_count), 2);
    // both pulses: hash precedence, router_done ignored
    run_txn(3, 2, 1'b0, -1, 2, 1, 1'b0);
    check_lit("both_txn_count", int'(tx_count), 3);
    // req dropped during BUSY -> single ACK cycle; counter wraps to 0
    run_txn(1, 2, 1'b0, 1, 0, 1, 1'b0);
    check_lit("wrap_count", int'(tx_count), 0);
    // no pulse at all -> straight to ACK
    run_txn(0, 0, 1'b0, -1, 1, 1, 1'b0);
    check_lit("none_txn_count", int'(tx_count), 1);

`ifdef HANDSHAKE_TIMEOUT_EN
    run_txn(1, 0, 1'b1, -1, 2, 1, 1'b0);
    check_lit("timeout_err", int'(op_error), 1);
    run_txn(2, 1, 1'b0, -1, 0, 1, 1'b0);
    check_lit("timeout_err_clear", int'(op_error), 0);
`endif

    reset_in_ack();
    run_txn(2, 1, 1'b0, -1, 1, 1, 1'b1);
    check_lit("after_reset_count", int'(tx_count), 1);

    for (int n = 0; n < 200; n++) begin
      k  = $urandom_range(0, 3);
      d  = $urandom_range(0, 5);
      nv = TMO_ON && (k != 0) && ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 5);
      h  = $urandom_range(0, 3);
      g  = $urandom_range(0, 2);
      run_txn(k, d, nv, r, h, g, 1'b0);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
